// File: rtl/rand_grant_arbiter.sv
// Round-robin arbiter that hands out one pseudo-random sample per grant,
// reduced to [0, LIMIT-1] plus OFFSET, with a cooldown so every grant sees a fresh generator value.
module rand_grant_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LIMIT   = 200,
    parameter int OFFSET  = 20,
    parameter int REFRESH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic [7:0]         rand_in,
    output logic [NUM_REQ-1:0] gnt,
    output logic [9:0]         rand_out,
    output logic               rand_valid,
    output logic               busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (REFRESH > 1) ? $clog2(REFRESH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] COOL  = 2'd2;

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] rr;

    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    int               cand;
    logic [7:0]       red;
    logic             can_grant;

    // Search upward from the slot after the last winner, wrapping around.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(rr) + i) % NUM_REQ;
            if (!win_found && req[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // LIMIT >= 128 keeps every 8-bit input below 2*LIMIT, so one subtract reduces fully.
    always_comb begin
        red = (rand_in >= 8'(LIMIT)) ? rand_in - 8'(LIMIT) : rand_in;
    end

    // The last COOL cycle arbitrates like IDLE, which gives REFRESH+1 grant spacing.
    always_comb begin
        can_grant = en && win_found &&
                    ((state == IDLE) || ((state == COOL) && (cnt == '0)));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            rr         <= PTR_W'(NUM_REQ - 1);
            gnt        <= '0;
            rand_valid <= 1'b0;
            rand_out   <= '0;
        end else begin
            gnt        <= '0;
            rand_valid <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                end
                GRANT: begin
                    cnt   <= CNT_W'(REFRESH - 1);
                    state <= COOL;
                end
                COOL: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            if (can_grant) begin
                gnt        <= ONE_HOT0 << win_idx;
                rand_valid <= 1'b1;
                rand_out   <= 10'(red) + 10'(OFFSET);
                rr         <= win_idx;
                state      <= GRANT;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rand_grant_arbiter.sv
// Self-checking bench for rand_grant_arbiter: vector table, hand-written corner
// sequences and a randomized run against a grant-timeline reference model.
module tb_rand_grant_arbiter;

    localparam int NREQ    = 4;
    localparam int LIMIT   = 200;
    localparam int OFFSET  = 20;
    localparam int REFRESH = 2;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic [NREQ-1:0] req;
    logic [7:0]      rand_in;
    logic [NREQ-1:0] gnt;
    logic [9:0]      rand_out;
    logic            rand_valid;
    logic            busy;

    rand_grant_arbiter #(
        .NUM_REQ (NREQ),
        .LIMIT   (LIMIT),
        .OFFSET  (OFFSET),
        .REFRESH (REFRESH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req        (req),
        .rand_in    (rand_in),
        .gnt        (gnt),
        .rand_out   (rand_out),
        .rand_valid (rand_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a grant may happen only if at least REFRESH+1 edges have
    // passed since the previous grant; busy covers the grant edge plus REFRESH edges.
    int              m_edge;
    int              m_last;
    int              m_rr;
    logic [NREQ-1:0] m_gnt;
    logic [9:0]      m_out;
    logic            m_busy;

    task automatic model_reset();
        m_edge = 0;
        m_last = -1000;
        m_rr   = NREQ - 1;
        m_gnt  = '0;
        m_out  = '0;
        m_busy = 1'b0;
    endtask

    task automatic model_edge();
        m_edge++;
        m_gnt = '0;
        if ((m_edge - m_last) >= REFRESH + 1 && en && (req != '0)) begin
            for (int i = 1; i <= NREQ; i++) begin
                int c;
                c = (m_rr + i) % NREQ;
                if (req[c]) begin
                    m_gnt  = '0;
                    m_gnt[c] = 1'b1;
                    m_rr   = c;
                    break;
                end
            end
            m_last = m_edge;
            m_out  = 10'((int'(rand_in) % LIMIT) + OFFSET);
        end
        m_busy = (m_edge - m_last) <= REFRESH;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".gnt"},   32'(gnt),        32'(m_gnt));
        check({tag, ".valid"}, 32'(rand_valid), 32'(m_gnt != '0));
        check({tag, ".busy"},  32'(busy),       32'(m_busy));
        if (m_gnt != '0) check({tag, ".out"}, 32'(rand_out), 32'(m_out));
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic step(input logic e, input logic [NREQ-1:0] r, input logic [7:0] x);
        en      = e;
        req     = r;
        rand_in = x;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, ".gnt"},   32'(gnt),        32'd0);
        check({tag, ".valid"}, 32'(rand_valid), 32'd0);
        check({tag, ".busy"},  32'(busy),       32'd0);
        check({tag, ".out"},   32'(rand_out),   32'd0);
    endtask

    task automatic do_reset();
        en    = 1'b0;
        req   = '0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic            en;
        logic [NREQ-1:0] req;
        logic [7:0]      rnd;
        logic [NREQ-1:0] gnt;
        logic            vld;
        logic [9:0]      out;
        logic            busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, input logic [NREQ-1:0] r, input logic [7:0] x,
                       input logic [NREQ-1:0] g, input logic v, input logic [9:0] o,
                       input logic b);
        vec_t t;
        t.en = e; t.req = r; t.rnd = x; t.gnt = g; t.vld = v; t.out = o; t.busy = b;
        vecs.push_back(t);
    endtask

    task automatic add_grant_and_cool(input logic [NREQ-1:0] r, input logic [7:0] x,
                                      input logic [9:0] o);
        add(1, r,    x, r,    1, o, 1);
        add(1, 4'h0, 0, 4'h0, 0, o, 1);
        add(1, 4'h0, 0, 4'h0, 0, o, 1);
        add(1, 4'h0, 0, 4'h0, 0, o, 0);
    endtask

    int              g_idx[$];
    int              g_edge[$];
    int              cyc;
    logic [NREQ-1:0] rq;

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        req     = '0;
        rand_in = '0;
        model_reset();
        #12;
        check_idle_zero("por");

        // ---- table: single requests, range boundaries, enable gating ----
        add_grant_and_cool(4'b0001, 8'd210, 10'd30);
        add_grant_and_cool(4'b0001, 8'd199, 10'd219);
        add_grant_and_cool(4'b0010, 8'd200, 10'd20);
        add_grant_and_cool(4'b0100, 8'd255, 10'd75);
        add_grant_and_cool(4'b1000, 8'd0,   10'd20);
        for (int i = 0; i < 10; i++) add(0, 4'b0010, 8'd77, 4'b0000, 0, 10'd20, 0);
        add(1, 4'b0010, 8'd77, 4'b0010, 1, 10'd97, 1);
        add(0, 4'b0010, 8'd5,  4'b0000, 0, 10'd97, 1);
        add(0, 4'b0010, 8'd5,  4'b0000, 0, 10'd97, 1);
        add(0, 4'b0010, 8'd5,  4'b0000, 0, 10'd97, 0);
        add(1, 4'b0010, 8'd5,  4'b0010, 1, 10'd25, 1);

        do_reset();
        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].req, vecs[i].rnd);
            check($sformatf("vec%0d.gnt", i),   32'(gnt),        32'(vecs[i].gnt));
            check($sformatf("vec%0d.valid", i), 32'(rand_valid), 32'(vecs[i].vld));
            check($sformatf("vec%0d.busy", i),  32'(busy),       32'(vecs[i].busy));
            if (vecs[i].vld) check($sformatf("vec%0d.out", i), 32'(rand_out), 32'(vecs[i].out));
        end

        // ---- round robin with all requests held ----
        do_reset();
        g_idx.delete();
        g_edge.delete();
        for (int c = 1; c <= 13; c++) begin
            step(1, 4'b1111, 8'($urandom));
            check_model("rr");
            if (gnt != '0) begin
                g_idx.push_back(onehot_idx(gnt));
                g_edge.push_back(c);
            end
        end
        check("rr.count", 32'(g_idx.size()), 32'd5);
        for (int i = 0; i < 5 && i < g_idx.size(); i++) begin
            check($sformatf("rr.order%0d", i), 32'(g_idx[i]), 32'(i % NREQ));
            if (i > 0) check($sformatf("rr.space%0d", i), 32'(g_edge[i] - g_edge[i-1]), 32'(REFRESH + 1));
        end

        // ---- fairness with a gap: only 0 and 2 ever win ----
        do_reset();
        g_idx.delete();
        for (int c = 1; c <= 12; c++) begin
            step(1, 4'b0101, 8'($urandom));
            check_model("gap");
            if (gnt != '0) g_idx.push_back(onehot_idx(gnt));
        end
        check("gap.count", 32'(g_idx.size()), 32'd4);
        for (int i = 0; i < g_idx.size(); i++)
            check($sformatf("gap.order%0d", i), 32'(g_idx[i]), 32'((i % 2) * 2));

        // ---- asynchronous reset in the middle of a GRANT ----
        do_reset();
        step(1, 4'b0010, 8'd10);
        check("arst.pre_gnt", 32'(gnt), 32'b0010);
        #2 rst_n = 1'b0;
        #1;
        check_idle_zero("arst.now");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1, 4'b1010, 8'd50);
        check("arst.ptr_restored", 32'(gnt), 32'b0010);
        check_model("arst");
        do_reset();
        step(1, 4'b1000, 8'd60);
        check("arst.req3", 32'(gnt), 32'b1000);
        check("arst.req3_out", 32'(rand_out), 32'd80);

        // ---- randomized run against the model ----
        do_reset();
        rq = '0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
            if (gnt != '0 && $urandom_range(0, 1) == 0) rq = rq & ~gnt;
            step($urandom_range(0, 9) != 0, rq, 8'($urandom));
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
